// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative
// shift-add multiplier that holds off new operations while it runs.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int SHW    = $clog2(WIDTH),
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovfl,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_RED    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_MEM1   = 4'b1001;
  localparam logic [3:0] OP_MEM2   = 4'b1010;
  localparam logic [3:0] OP_MEM3   = 4'b1011;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mplier;
  logic [SHW-1:0]       r_cnt;

  logic [WIDTH-1:0]     r_out;
  logic                 r_ovfl;
  logic                 r_zero;
  logic                 r_out_valid;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_start_mul;
  logic                 w_load_alu;
  logic                 w_load_mul;
  logic                 w_mul_last;

  logic [SHW-1:0]       w_sh;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_add_ovf;
  logic                 w_sub_ovf;
  logic [WIDTH-1:0]     w_red;
  logic [WIDTH-1:0]     w_padd;
  logic [WIDTH-1:0]     w_ror;
  logic [WIDTH-1:0]     w_res;
  logic                 w_res_ovfl;
  logic [WIDTH-1:0]     w_mul_lo;
  logic                 w_mul_hi_nz;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = MUL_EN && (op == OP_MUL);
  assign w_start_mul = w_accept && w_is_mul;
  assign w_load_alu  = w_accept && !w_is_mul;
  assign w_load_mul  = (r_state == S_DONE);
  assign w_mul_last  = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH-1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_mul) w_next = S_MUL;
      S_MUL:   if (w_mul_last)  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs. The output slot is guaranteed empty on the DONE cycle
  // because a MUL is only accepted once the slot clears.
  always_comb begin
    in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    busy     = (r_state != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Shift-add multiplier datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (w_start_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_acc    <= '0;
      r_mplier <= B;
      r_cnt    <= '0;
    end else if (r_state == S_MUL) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign w_mul_lo    = r_acc[WIDTH-1:0];
  assign w_mul_hi_nz = |r_acc[2*WIDTH-1:WIDTH];

  // ---------------------------------------------------------------------------
  // Single-cycle operation datapath
  // ---------------------------------------------------------------------------
  assign w_sh   = B[SHW-1:0];
  assign w_sum  = A + B;
  assign w_diff = A - B;

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the
  // result sign departs from A; saturation direction follows A's sign.
  assign w_add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1]  != A[WIDTH-1]);
  assign w_sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

  assign w_ror = (A >> w_sh) | (A << (WIDTH - int'(w_sh)));

  always_comb begin
    w_red = '0;
    for (int i = 0; i < WIDTH/8; i++) begin
      w_red = w_red + WIDTH'($signed(A[8*i +: 8])) + WIDTH'($signed(B[8*i +: 8]));
    end
  end

  always_comb begin : p_padd
    logic [4:0] v_lane;
    v_lane = '0;
    w_padd = '0;
    for (int i = 0; i < WIDTH/4; i++) begin
      v_lane = {A[4*i+3], A[4*i +: 4]} + {B[4*i+3], B[4*i +: 4]};
      if (v_lane[4] != v_lane[3]) begin
        w_padd[4*i +: 4] = v_lane[4] ? 4'h8 : 4'h7;
      end else begin
        w_padd[4*i +: 4] = v_lane[3:0];
      end
    end
  end

  // NOTE: defaults ahead of the case keep every path assigned, so no latch
  // is inferred for opcodes that leave a signal untouched.
  always_comb begin
    w_res      = '0;
    w_res_ovfl = 1'b0;
    case (op)
      OP_ADD: begin
        w_res      = w_add_ovf ? (A[WIDTH-1] ? SAT_NEG : SAT_POS) : w_sum;
        w_res_ovfl = w_add_ovf;
      end
      OP_SUB: begin
        w_res      = w_sub_ovf ? (A[WIDTH-1] ? SAT_NEG : SAT_POS) : w_diff;
        w_res_ovfl = w_sub_ovf;
      end
      OP_RED:    w_res = w_red;
      OP_XOR:    w_res = A ^ B;
      OP_SLL:    w_res = A << w_sh;
      OP_SRA:    w_res = $signed(A) >>> w_sh;
      OP_ROR:    w_res = w_ror;
      OP_PADDSB: w_res = w_padd;
      OP_MUL, OP_MEM1, OP_MEM2, OP_MEM3: w_res = A + (B << 1);
      default:   w_res = w_sum;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register: loads from the ALU on accept or from the multiplier on
  // DONE, otherwise holds until the consumer takes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= '0;
      r_ovfl      <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load_alu) begin
      r_out       <= w_res;
      r_ovfl      <= w_res_ovfl;
      r_zero      <= (w_res == '0);
      r_out_valid <= 1'b1;
    end else if (w_load_mul) begin
      r_out       <= w_mul_lo;
      r_ovfl      <= w_mul_hi_nz;
      r_zero      <= (w_mul_lo == '0);
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out       = r_out;
  assign ovfl      = r_ovfl;
  assign zero      = r_zero;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16: ALU ops, MUL timing,
// backpressure and asynchronous reset during a multiply.
module tb_alu_seq;

  localparam int W = 16;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, RED = 4'b0010,
                         XOR = 4'b0011, SLL = 4'b0100, SRA = 4'b0101,
                         ROR = 4'b0110, PAD = 4'b0111, MUL = 4'b1000,
                         MEM = 4'b1001, MEM3 = 4'b1011,
                         CT0 = 4'b1100, CT3 = 4'b1111;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         ovfl;
  logic         zero;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (a),
    .B         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovfl      (ovfl),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle op with out_ready high: accepted now, result next cycle.
  task automatic run1(input string tag, input logic [3:0] o, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic [W-1:0] e_out,
                      input logic e_ovfl, input logic e_zero);
    in_valid = 1'b1; op = o; a = av; b = bv;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out"},       32'(out),       32'(e_out));
    check({tag, " ovfl"},      32'(ovfl),      32'(e_ovfl));
    check({tag, " zero"},      32'(zero),      32'(e_zero));
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] e_out, input logic e_ovfl, input logic e_zero);
    int n;
    in_valid = 1'b1; op = MUL; a = av; b = bv;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      check({tag, " {out_valid,busy,in_ready} while running"},
            32'({out_valid, busy, in_ready}), 32'b010);
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd17);
    check({tag, " out"},     32'(out),  32'(e_out));
    check({tag, " ovfl"},    32'(ovfl), 32'(e_ovfl));
    check({tag, " zero"},    32'(zero), 32'(e_zero));
    check({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (3) tick();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out",       32'(out),       32'd0);
    check("reset ovfl",      32'(ovfl),      32'd0);
    check("reset zero",      32'(zero),      32'd0);
    check("reset busy",      32'(busy),      32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Saturating add/sub
    run1("ADD pos sat", ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    run1("ADD neg sat", ADD, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0);
    run1("ADD plain",   ADD, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0);
    run1("SUB zero",    SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1);
    run1("SUB neg sat", SUB, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0);
    run1("SUB pos sat", SUB, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0);
    // Byte reduction and logic
    run1("RED small",   RED, 16'h01FF, 16'h0203, 16'h0005, 1'b0, 1'b0);
    run1("RED neg",     RED, 16'h8080, 16'h8080, 16'hFE00, 1'b0, 1'b0);
    run1("XOR",         XOR, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0);
    // Shifts (only B[3:0] used)
    run1("SLL masked",  SLL, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0);
    run1("SRA",         SRA, 16'h8000, 16'h0003, 16'hF000, 1'b0, 1'b0);
    run1("ROR 4",       ROR, 16'h8001, 16'h0004, 16'h1800, 1'b0, 1'b0);
    run1("ROR 0",       ROR, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0);
    run1("ROR masked",  ROR, 16'h1234, 16'h0014, 16'h4123, 1'b0, 1'b0);
    // Nibble lanes
    run1("PADDSB mix",  PAD, 16'h7F18, 16'h1111, 16'h7029, 1'b0, 1'b0);
    run1("PADDSB neg",  PAD, 16'h8888, 16'h8888, 16'h8888, 1'b0, 1'b0);
    // Address and control adds, wrapping
    run1("MEM",         MEM,  16'h0100, 16'h0010, 16'h0120, 1'b0, 1'b0);
    run1("MEM wrap",    MEM3, 16'hFFFF, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
    run1("CTRL wrap",   CT0,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1);
    run1("CTRL",        CT3,  16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0);

    // Iterative multiply
    run_mul("MUL small", 16'h0012, 16'h0003, 16'h0036, 1'b0, 1'b0);
    run_mul("MUL high",  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1);
    run_mul("MUL max",   16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0);

    // Backpressure: drain, then hold the result with out_ready low
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    run1("BP ADD", ADD, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0);
    in_valid = 1'b1; op = SUB; a = 16'h0009; b = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("BP hold in_ready",  32'(in_ready),  32'd0);
      check("BP hold out_valid", 32'(out_valid), 32'd1);
      check("BP hold out",       32'(out),       32'h0030);
      check("BP hold flags",     32'({ovfl, zero}), 32'b00);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("BP release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("BP same-edge out_valid", 32'(out_valid), 32'd1);
    check("BP same-edge out",       32'(out),       32'h0007);
    tick();
    check("BP no queued op", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a multiply
    in_valid = 1'b1; op = MUL; a = 16'h0012; b = 16'h0003;
    #1;
    check("RST mul in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("RST pre busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("RST async out_valid", 32'(out_valid), 32'd0);
    check("RST async out",       32'(out),       32'd0);
    check("RST async ovfl",      32'(ovfl),      32'd0);
    check("RST async zero",      32'(zero),      32'd0);
    check("RST async busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("RST after {out_valid,in_ready,busy}",
            32'({out_valid, in_ready, busy}), 32'b010);
    end
    run1("post-reset ADD", ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
